sd_sector_cache: RTL
====================

// Module: sd_sector_cache
// PURPOSE
//  Single-sector read cache that consumes the byte stream of the SD SPI block-read interface.
//  Clients (e.g. the cartridge ROM fetch path) request any 32-bit byte address.
//  A hit is served from a local 512-byte buffer. A miss issues one SD block read, fills the
//  buffer, then serves the request. It sits directly downstream of the SD SPI interface.
// PARAMETERS
//  SECTOR_BYTES  512       bytes per SD block; power of two; sets buffer depth and fill count
//  BLOCK_ADDR    1         1: sd_addr = sector index (SDHC); 0: sd_addr = sector*SECTOR_BYTES (SDSC)
//  TIMEOUT       1<<20     clocks allowed from sd_begin_read to the last fill byte before error
// PORTS
//  clock         in   1   system clock
//  reset         in   1   synchronous, active-high
//  req           in   1   client read request; must be held until req_ready is seen high
//  req_addr      in   32  byte address of the request
//  req_ready     out  1   high in IDLE; req accepted on the cycle req && req_ready
//  rd_valid      out  1   one-cycle pulse; rd_data is valid in that cycle
//  rd_data       out  8   requested byte; holds its value until the next rd_valid
//  busy          out  1   high while a fill is in progress (ISSUE..DRAIN)
//  err           out  1   sticky fill-timeout flag; cleared only by reset
//  sd_begin_read out  1   one-cycle pulse to the SD interface
//  sd_addr       out  32  block address for the SD interface; stable from pulse to fill end
//  sd_idle       in   1   SD interface is idle and ready for a command
//  sd_valid      in   1   SD interface is streaming data bytes
//  sd_byte_stb   in   1   one-cycle pulse per new byte on sd_byte (driven from SPI byte_ready)
//  sd_byte       in   8   data byte from the SD interface
// BEHAVIOUR
//  Reset: req_ready=0 for one cycle, then 1. rd_valid=0, rd_data=0, busy=0, err=0.
//   Also on reset: sd_begin_read=0, sd_addr=0, tag_valid=0, fill counter=0.
//  Tag: tag = req_addr[31:log2(SECTOR_BYTES)]; offset = low log2(SECTOR_BYTES) bits.
//  FSM states: IDLE, LOOKUP, ISSUE, FILL, DRAIN, READ, RESP, ERROR.
//   IDLE:   on req&&req_ready, latch addr -> LOOKUP.
//   LOOKUP: tag_valid && tag==latched tag -> READ (hit). Else -> ISSUE, clearing tag_valid.
//   ISSUE:  wait for sd_idle. In that cycle pulse sd_begin_read and drive sd_addr per
//           BLOCK_ADDR. Clear the counter and timer, then -> FILL.
//   FILL:   each sd_byte_stb && sd_valid writes sd_byte to buf[cnt], then cnt++.
//           When cnt reaches SECTOR_BYTES-1 and that byte is written: set tag_valid and the tag,
//           then -> DRAIN. Strobes without sd_valid are ignored.
//   DRAIN:  wait for sd_idle (the interface clocks out its trailing CRC bytes) -> READ.
//           Strobes arriving in DRAIN are ignored and never written.
//   READ:   drive the buffer read address with the offset; synchronous RAM -> RESP.
//   RESP:   rd_data <= RAM output, rd_valid=1 for this cycle -> IDLE.
//   ERROR:  entered when the timer hits TIMEOUT in ISSUE/FILL/DRAIN. err=1, tag_valid=0.
//           req_ready stays 0; the state is held until reset.
//  Latency, counted from the acceptance cycle (req&&req_ready) to the rd_valid cycle:
//   hit = 3 cycles (LOOKUP, READ, RESP). Miss = depends on the SD interface, plus 3.
//  Back-to-back: req_ready returns to 1 the cycle after RESP. Hits can therefore be accepted
//   every 4 cycles.
//  Reset mid-fill: returns to IDLE with tag_valid=0. Partial buffer data is never served.
//  Address wrap: the offset is taken modulo SECTOR_BYTES, so addr 0xFFFFFFFF maps to tag
//   0x7FFFFF, offset 0x1FF.
//  BLOCK_ADDR=0: sd_addr = {tag, offset=0}, the byte address of the sector start.
//  Simultaneous req and fill completion cannot occur, because req_ready=0 while busy.
//  The counter and timer are sized by the parameters. They never wrap inside FILL.
// STRUCTURE
//  Package sd_cache_pkg: FSM state enum, SECTOR_BYTES, OFFSET_W=$clog2(SECTOR_BYTES),
//   and TAG_W = 32-OFFSET_W.
//  Sub-module sd_sector_ram: SECTOR_BYTES x 8, one write port, one synchronous read port,
//   with no reset on the array.
//  Top: FSM, tag register, fill counter, timeout timer, output registers.
// TESTING
//  1 Cold miss: req 0x00000205, BLOCK_ADDR=1, model streams byte i = i^8'h5A
//    -> one sd_begin_read with sd_addr=1; rd_data=8'h5F; err=0.
//  2 Hit after 1: req 0x000003FF -> no sd_begin_read; rd_valid exactly 3 cycles after
//    acceptance; rd_data=8'hA5.
//  3 Miss to a new sector: req 0x00000400 -> sd_addr=2, and the refill pattern (i+1)&8'hFF
//    gives rd_data=8'h01.
//    BLOCK_ADDR=0 variant -> sd_addr=32'h00000400.
//  4 Timeout: TIMEOUT=1000, model stops after 100 bytes -> err=1 at cycle 1000 after the pulse;
//    req_ready stays 0.
//  5 Reset mid-fill after 300 bytes, then req 0x00000205 -> a fresh sd_begin_read;
//    the served byte comes from the new fill only.
//  6 Spurious traffic: sd_byte_stb pulses in IDLE, and 3 extra strobes in DRAIN -> the buffer
//    is unchanged; a follow-up hit on offset 0 returns the original byte.

Source files
------------

// File: rtl/sd_cache_pkg.sv
// Shared constants and FSM encoding for the single-sector SD read cache.
package sd_cache_pkg;

  localparam int SECTOR_BYTES = 512;
  localparam int OFFSET_W     = $clog2(SECTOR_BYTES);
  localparam int TAG_W        = 32 - OFFSET_W;

  // Plain 3-bit encoding so the state can be exported and decoded by checkers.
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOOKUP = 3'd1;
  localparam state_t ST_ISSUE  = 3'd2;
  localparam state_t ST_FILL   = 3'd3;
  localparam state_t ST_DRAIN  = 3'd4;
  localparam state_t ST_READ   = 3'd5;
  localparam state_t ST_RESP   = 3'd6;
  localparam state_t ST_ERROR  = 3'd7;

endpackage

// File: rtl/sd_sector_ram.sv
// Sector buffer: one write port, one registered read port, no reset on the array.
module sd_sector_ram
  import sd_cache_pkg::*;
#(
  parameter int DEPTH = SECTOR_BYTES,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rdata;

  // Fill-side write.
  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read; data appears the cycle after i_re.
  always_ff @(posedge clock) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sd_sector_cache.sv
// Single-sector read cache in front of the SD SPI block-read stream.
// Request handshake: a request is taken on the clock edge where i_req and
// o_req_ready are both high; the client holds i_req and i_req_addr until then.
// The answer is a single o_rd_valid pulse with o_rd_data valid in that cycle.
module sd_sector_cache
  import sd_cache_pkg::*;
#(
  parameter int SECTOR_BYTES = sd_cache_pkg::SECTOR_BYTES,
  parameter int BLOCK_ADDR   = 1,
  parameter int TIMEOUT      = 1 << 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_req_addr,
  output logic        o_req_ready,
  output logic        o_rd_valid,
  output logic [7:0]  o_rd_data,
  output logic        o_busy,
  output logic        o_err,
  output logic        o_sd_begin_read,
  output logic [31:0] o_sd_addr,
  input  logic        i_sd_idle,
  input  logic        i_sd_valid,
  input  logic        i_sd_byte_stb,
  input  logic [7:0]  i_sd_byte,
  output state_t      o_state
);

  localparam int OFF_W = $clog2(SECTOR_BYTES);
  localparam int TG_W  = 32 - OFF_W;
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [OFF_W-1:0] LAST_IDX  = OFF_W'(SECTOR_BYTES - 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT - 1);

  state_t            r_state;
  logic              r_ready_en;
  logic [31:0]       r_addr;
  logic [TG_W-1:0]   r_tag;
  logic              r_tag_valid;
  logic [OFF_W-1:0]  r_cnt;
  logic [TMR_W-1:0]  r_timer;
  logic [31:0]       r_sd_addr;
  logic [7:0]        r_rd_data;
  logic              r_err;

  logic              w_req_acc;
  logic              w_hit;
  logic              w_fill_we;
  logic              w_timeout;
  logic [7:0]        w_ram_q;
  logic [31:0]       w_sd_addr_next;

  assign w_req_acc = i_req && o_req_ready;
  assign w_hit     = r_tag_valid && (r_tag == r_addr[31:OFF_W]);
  assign w_fill_we = (r_state == ST_FILL) && i_sd_byte_stb && i_sd_valid;
  // The pulse cycle loads the timer with 1, so the error lands TIMEOUT cycles after it.
  assign w_timeout = (r_timer == TMR_LIMIT);

  // SD block address: sector index for SDHC, sector start byte address for SDSC.
  always_comb begin
    w_sd_addr_next = {r_addr[31:OFF_W], {OFF_W{1'b0}}};
    if (BLOCK_ADDR != 0) w_sd_addr_next = 32'(r_addr[31:OFF_W]);
  end

  // Main FSM with tag, fill counter, timeout timer and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ready_en  <= 1'b0;
      r_addr      <= '0;
      r_tag       <= '0;
      r_tag_valid <= 1'b0;
      r_cnt       <= '0;
      r_timer     <= '0;
      r_sd_addr   <= '0;
      r_rd_data   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_req_acc) begin
            r_addr  <= i_req_addr;
            r_state <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (w_hit) begin
            r_state <= ST_READ;
          end else begin
            r_tag_valid <= 1'b0;
            r_sd_addr   <= w_sd_addr_next;
            r_timer     <= '0;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (i_sd_idle) begin
            r_cnt   <= '0;
            r_timer <= TMR_W'(1);
            r_state <= ST_FILL;
          end else if (w_timeout) begin
            r_err       <= 1'b1;
            r_tag_valid <= 1'b0;
            r_state     <= ST_ERROR;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_FILL: begin
          if (w_timeout) begin
            r_err       <= 1'b1;
            r_tag_valid <= 1'b0;
            r_state     <= ST_ERROR;
          end else begin
            r_timer <= r_timer + 1'b1;
            if (w_fill_we) begin
              r_cnt <= r_cnt + 1'b1;
              if (r_cnt == LAST_IDX) begin
                r_tag_valid <= 1'b1;
                r_tag       <= r_addr[31:OFF_W];
                r_state     <= ST_DRAIN;
              end
            end
          end
        end
        ST_DRAIN: begin
          if (w_timeout) begin
            r_err       <= 1'b1;
            r_tag_valid <= 1'b0;
            r_state     <= ST_ERROR;
          end else begin
            r_timer <= r_timer + 1'b1;
            if (i_sd_idle) r_state <= ST_READ;
          end
        end
        ST_READ: r_state <= ST_RESP;
        ST_RESP: begin
          r_rd_data <= w_ram_q;
          r_state   <= ST_IDLE;
        end
        ST_ERROR: begin
          r_err       <= 1'b1;
          r_tag_valid <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  sd_sector_ram #(
    .DEPTH (SECTOR_BYTES),
    .AW    (OFF_W)
  ) u_ram (
    .clock   (clock),
    .i_we    (w_fill_we),
    .i_waddr (r_cnt),
    .i_wdata (i_sd_byte),
    .i_re    (r_state == ST_READ),
    .i_raddr (r_addr[OFF_W-1:0]),
    .o_rdata (w_ram_q)
  );

  assign o_req_ready     = (r_state == ST_IDLE) && r_ready_en;
  assign o_rd_valid      = (r_state == ST_RESP);
  assign o_rd_data       = (r_state == ST_RESP) ? w_ram_q : r_rd_data;
  assign o_busy          = (r_state == ST_ISSUE) || (r_state == ST_FILL) || (r_state == ST_DRAIN);
  assign o_err           = r_err;
  assign o_sd_begin_read = (r_state == ST_ISSUE) && i_sd_idle;
  assign o_sd_addr       = r_sd_addr;
  assign o_state         = r_state;

endmodule
